interleaver_commutator: RTL and testbench
=========================================

Name: interleaver_commutator

Overview:
- Input/output commutator for the convolutional byte interleaver.
- Takes the incoming byte stream and steers each byte to one branch delay line. Branch j is a reg_buffer chain of j*17 stages (branch 7 = 119 stages).
- Gathers the delayed byte from the same branch and presents the interleaved stream downstream.
- Branch 0 has no delay line; its zero-delay path is internal to this block.

Parameters:
- NUM_BRANCH, 12, number of interleaver branches (I).
- DATA_W, 8, byte width.
- PTR_W, 4, branch pointer width (>= clog2(NUM_BRANCH)).

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  in_data is valid this cycle
- in_data  input  DATA_W  input byte
- in_sync  input  1  qualified by in_valid; this byte is a packet sync byte and must go to branch 0
- buf_en  output  NUM_BRANCH  one-hot shift enable to branches; bit 0 unused, always 0
- buf_data  output  DATA_W  byte broadcast to every branch data_in
- branch_out  input  NUM_BRANCH*DATA_W  concatenated branch data_out, branch j at [j*DATA_W +: DATA_W]; slice 0 ignored
- out_valid  output  1  out_data is valid
- out_data  output  DATA_W  interleaved output byte
- branch_idx  output  PTR_W  branch that produced out_data
- sync_err  output  1  one-cycle pulse when in_sync arrives while the pointer is not 0

Behaviour:
- Reset (synchronous, active-high): ptr=0, buf_en=0, buf_data=0, out_valid=0, out_data=0, branch_idx=0, sync_err=0, and all pipeline valids cleared. A reset asserted mid-stream drops in-flight bytes. Branch contents are cleared by the branches' own reset.
- Stage 1, capture (edge ending cycle t, in_valid=1):
  - Effective branch p = 0 if in_sync, else ptr.
  - buf_data <= in_data.
  - buf_en <= one-hot(p) when p!=0, else all zeros.
  - Register s1_valid=1 and s1_idx=p.
  - ptr <= (p==NUM_BRANCH-1) ? 0 : p+1.
  - sync_err <= in_sync && ptr!=0. The pointer realigns to 0; no byte is dropped.
- If in_valid=0: buf_en <= 0, s1_valid <= 0, ptr holds, buf_data holds its last value.
- buf_en is high for exactly one cycle per accepted byte. The branch shifts on that edge.
- Stage 2, collect (edge ending cycle t+2): if s2_valid, out_data <= branch_out[s2_idx], or the held stage-1 byte when s2_idx==0. Also branch_idx <= s2_idx and out_valid <= 1.
  - The s2 registers are s1 delayed one cycle. This guarantees the branch has shifted before its output is sampled.
- Latency: fixed 3 cycles from in_valid to out_valid for every branch. Interleaving delay is carried by the branches, not here.
- Throughput: one byte per cycle. Back-to-back and gapped in_valid are both legal. Gaps never advance ptr.
- Wrap: after branch NUM_BRANCH-1 the next byte goes to branch 0.
- A simultaneous in_sync at ptr==0 is normal operation: no sync_err, same path as any other byte.
- in_sync with in_valid=0 is ignored.
- No backpressure: downstream must accept every out_valid cycle.

Test Plan:
- Reset then idle
  - Stimulus: reset=1 for 2 cycles, then release.
  - Required: all outputs 0, ptr=0, and buf_en stays 0 with in_valid=0.
- 24 back-to-back bytes 0x00..0x17, first with in_sync=1
  - buf_en follows 0x000,0x002,0x004..0x800, then repeats (byte 0x0C goes to branch 0).
  - out_valid rises 3 cycles after the first byte; branch_idx runs 0..11,0..11.
- Branch-0 path
  - Stimulus: single byte 0xA5 with in_sync.
  - Required: buf_en stays 0, out_data=0xA5 with branch_idx=0 exactly 3 cycles later.
- Gapped input
  - Stimulus: bytes on alternate cycles.
  - Required: ptr advances only on valid cycles, buf_en pulses are single-cycle, and out_valid mirrors the input pattern delayed by 3.
- Misaligned sync
  - Stimulus: in_sync on the 5th byte (ptr=4).
  - Required: sync_err pulses once, that byte goes to branch 0, and the next byte goes to branch 1.
- Reset mid-stream
  - Stimulus: assert reset on the cycle after byte 7 is accepted.
  - Required: out_valid=0 next cycle, and the first byte after release goes to branch 0.
- Full interleaver, with 11 reg_buffer branches attached (branch j delays j*17 enables)
  - Stimulus: incrementing stream.
  - Required: a byte steered to branch 7 appears at out_data on branch 7's 120th enable, i.e. 119 branch-7 enables after its own.

Source files
------------

// File: rtl/interleaver_commutator_if.sv
// Bus bundle between the interleaver commutator and its surroundings:
// byte stream in, branch delay-line taps, interleaved stream out.
interface interleaver_commutator_if #(
    parameter int NUM_BRANCH = 12,
    parameter int DATA_W     = 8,
    parameter int PTR_W      = 4
);
    logic                         in_valid;
    logic [DATA_W-1:0]            in_data;
    logic                         in_sync;
    logic [NUM_BRANCH-1:0]        buf_en;
    logic [DATA_W-1:0]            buf_data;
    logic [NUM_BRANCH*DATA_W-1:0] branch_out;
    logic                         out_valid;
    logic [DATA_W-1:0]            out_data;
    logic [PTR_W-1:0]             branch_idx;
    logic                         sync_err;

    // Environment side: sources the stream and the branch taps.
    modport master (
        output in_valid, in_data, in_sync, branch_out,
        input  buf_en, buf_data, out_valid, out_data, branch_idx, sync_err
    );

    // Commutator side.
    modport slave (
        input  in_valid, in_data, in_sync, branch_out,
        output buf_en, buf_data, out_valid, out_data, branch_idx, sync_err
    );
endinterface

// File: rtl/interleaver_commutator.sv
// Input/output commutator of the convolutional byte interleaver: steers each
// byte into one branch delay line and collects the delayed byte from it.
module interleaver_commutator #(
    parameter int NUM_BRANCH = 12,
    parameter int DATA_W     = 8,
    parameter int PTR_W      = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    interleaver_commutator_if.slave bus
);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_BRANCH - 1);

    logic [PTR_W-1:0]      ptr_r;
    logic [NUM_BRANCH-1:0] buf_en_r;
    logic [DATA_W-1:0]     buf_data_r;
    logic                  s1_valid_r;
    logic [PTR_W-1:0]      s1_idx_r;
    logic                  sync_err_r;
    logic                  s2_valid_r;
    logic [PTR_W-1:0]      s2_idx_r;
    logic [DATA_W-1:0]     s2_data_r;
    logic                  out_valid_r;
    logic [DATA_W-1:0]     out_data_r;
    logic [PTR_W-1:0]      branch_idx_r;

    logic [PTR_W-1:0]      eff_idx_s;
    logic [PTR_W-1:0]      next_ptr_s;
    logic [NUM_BRANCH-1:0] onehot_s;
    logic [DATA_W-1:0]     collect_s;

    // Branch selection for the incoming byte and tap selection for the outgoing one.
    always_comb begin
        eff_idx_s  = ptr_r;
        next_ptr_s = '0;
        onehot_s   = '0;
        collect_s  = s2_data_r;
        if (bus.in_sync) begin
            eff_idx_s = '0;
        end else begin
            eff_idx_s = ptr_r;
        end
        if (eff_idx_s == LAST_IDX) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = eff_idx_s + PTR_W'(1);
        end
        // Branch 0 has no delay line, so it never gets a shift enable.
        for (int i = 1; i < NUM_BRANCH; i++) begin
            onehot_s[i] = (eff_idx_s == PTR_W'(i));
        end
        // Branch 0 returns the byte held from the capture stage.
        for (int i = 1; i < NUM_BRANCH; i++) begin
            collect_s = (s2_idx_r == PTR_W'(i)) ? bus.branch_out[i*DATA_W +: DATA_W] : collect_s;
        end
    end

    // Capture, alignment and collect pipeline registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_r        <= '0;
            buf_en_r     <= '0;
            buf_data_r   <= '0;
            s1_valid_r   <= 1'b0;
            s1_idx_r     <= '0;
            sync_err_r   <= 1'b0;
            s2_valid_r   <= 1'b0;
            s2_idx_r     <= '0;
            s2_data_r    <= '0;
            out_valid_r  <= 1'b0;
            out_data_r   <= '0;
            branch_idx_r <= '0;
        end else begin
            if (bus.in_valid) begin
                buf_data_r <= bus.in_data;
                buf_en_r   <= onehot_s;
                s1_valid_r <= 1'b1;
                s1_idx_r   <= eff_idx_s;
                ptr_r      <= next_ptr_s;
                sync_err_r <= bus.in_sync && (ptr_r != '0);
            end else begin
                buf_en_r   <= '0;
                s1_valid_r <= 1'b0;
                sync_err_r <= 1'b0;
            end
            // One extra stage so the selected branch has shifted before its tap is read.
            s2_valid_r  <= s1_valid_r;
            s2_idx_r    <= s1_idx_r;
            s2_data_r   <= buf_data_r;
            out_valid_r <= s2_valid_r;
            if (s2_valid_r) begin
                out_data_r   <= collect_s;
                branch_idx_r <= s2_idx_r;
            end else begin
                out_data_r   <= out_data_r;
                branch_idx_r <= branch_idx_r;
            end
        end
    end

    assign bus.buf_en     = buf_en_r;
    assign bus.buf_data   = buf_data_r;
    assign bus.sync_err   = sync_err_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.out_data   = out_data_r;
    assign bus.branch_idx = branch_idx_r;
endmodule

// File: tb/tb_interleaver_commutator.sv
// Directed bench for interleaver_commutator with behavioural branch delay lines
// (branch j holds j*17 bytes) attached to the broadcast bus.
module tb_interleaver_commutator;
    localparam int NB   = 12;
    localparam int DW   = 8;
    localparam int PW   = 4;
    localparam int SEG  = 17;
    localparam int MAXD = (NB - 1) * SEG;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    interleaver_commutator_if #(.NUM_BRANCH(NB), .DATA_W(DW), .PTR_W(PW)) bus ();

    interleaver_commutator #(.NUM_BRANCH(NB), .DATA_W(DW), .PTR_W(PW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [DW-1:0] bmem [1:NB-1][0:MAXD-1];
    logic [DW-1:0] bout [1:NB-1];

    // Branch j: on each enable the byte entered j*17 enables earlier appears on its tap.
    always @(posedge clk) begin
        for (int j = 1; j < NB; j++) begin
            if (reset) begin
                bout[j] <= '0;
                for (int s = 0; s < MAXD; s++) bmem[j][s] <= '0;
            end else if (bus.buf_en[j]) begin
                bout[j] <= bmem[j][j*SEG-1];
                for (int s = 1; s < MAXD; s++) begin
                    if (s < j*SEG) bmem[j][s] <= bmem[j][s-1];
                end
                bmem[j][0] <= bus.buf_data;
            end
        end
    end

    always_comb begin
        bus.branch_out = '0;
        for (int j = 1; j < NB; j++) bus.branch_out[j*DW +: DW] = bout[j];
    end

    int tests = 0;
    int fails = 0;
    logic       hv_v [0:1];
    int         hv_i [0:1];
    logic [7:0] hv_d [0:1];
    logic       fresh;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_hist();
        for (int i = 0; i < 2; i++) begin
            hv_v[i] = 1'b0;
            hv_i[i] = 0;
            hv_d[i] = 8'h00;
        end
    endtask

    // One cycle of stimulus; outputs seen after it belong to the byte two steps back.
    task automatic step(input logic v, input logic [7:0] d, input logic s, input int br, input logic err);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.in_sync  = s;
        tick();
        check("buf_en", 32'(bus.buf_en), (v && br != 0) ? (32'd1 << br) : 32'd0);
        if (v) check("buf_data", 32'(bus.buf_data), 32'(d));
        check("sync_err", 32'(bus.sync_err), 32'(err));
        check("out_valid", 32'(bus.out_valid), 32'(hv_v[1]));
        if (hv_v[1]) begin
            check("branch_idx", 32'(bus.branch_idx), 32'(hv_i[1]));
            if (hv_i[1] == 0) check("out_data_b0", 32'(bus.out_data), 32'(hv_d[1]));
            else if (fresh) check("out_data_empty", 32'(bus.out_data), 32'd0);
        end
        hv_v[1] = hv_v[0]; hv_i[1] = hv_i[0]; hv_d[1] = hv_d[0];
        hv_v[0] = v;       hv_i[0] = br;      hv_d[0] = d;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_sync  = 1'b0;
        tick();
        tick();
        check("rst_buf_en", 32'(bus.buf_en), 32'd0);
        check("rst_buf_data", 32'(bus.buf_data), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_branch_idx", 32'(bus.branch_idx), 32'd0);
        check("rst_sync_err", 32'(bus.sync_err), 32'd0);
        reset = 1'b0;
        clear_hist();
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_sync  = 1'b0;
        fresh        = 1'b1;
        clear_hist();

        // Reset then idle
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 0, 1'b0);

        // 24 back-to-back bytes, first one flagged sync
        for (int k = 0; k < 24; k++) step(1'b1, 8'(k), (k == 0), k % 12, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 0, 1'b0);

        // Lone sync byte through the zero-delay branch
        step(1'b1, 8'hA5, 1'b1, 0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 0, 1'b0);

        // Alternate-cycle input starting at branch 1
        for (int c = 0; c < 14; c++) begin
            if (c < 12 && c % 2 == 0) step(1'b1, 8'(8'h30 + c / 2), 1'b0, 1 + c / 2, 1'b0);
            else step(1'b0, 8'h00, 1'b0, 0, 1'b0);
        end

        // Sync on the fifth byte realigns the pointer
        do_reset();
        for (int k = 0; k < 6; k++) step(1'b1, 8'(8'h40 + k), (k == 4), (k < 4) ? k : k - 4, (k == 4));
        for (int i = 0; i < 2; i++) step(1'b0, 8'h00, 1'b0, 0, 1'b0);

        // Reset right after byte 7, pointer currently at 2
        for (int k = 0; k < 8; k++) step(1'b1, 8'(8'h50 + k), 1'b0, (2 + k) % 12, 1'b0);
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        tick();
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_buf_en", 32'(bus.buf_en), 32'd0);
        reset = 1'b0;
        clear_hist();
        step(1'b1, 8'h60, 1'b0, 0, 1'b0);
        step(1'b1, 8'h61, 1'b0, 1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 0, 1'b0);

        // Full interleaver: incrementing stream through the attached branches
        do_reset();
        fresh = 1'b0;
        for (int n = 0; n < 1440; n++) begin
            step(1'b1, 8'(n), 1'b0, n % 12, 1'b0);
            if (n - 2 == 615) begin
                check("full_b3_idx", 32'(bus.branch_idx), 32'd3);
                check("full_b3_data", 32'(bus.out_data), 32'h03);
            end
            if (n - 2 == 1423) check("full_b7_early", 32'(bus.out_data), 32'h00);
            if (n - 2 == 1435) begin
                check("full_b7_idx", 32'(bus.branch_idx), 32'd7);
                check("full_b7_data", 32'(bus.out_data), 32'h07);
            end
        end
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
